// File: rtl/alu0_xbar_datapath_pkg.sv
// alu0_xbar_datapath_pkg: shared opcodes, config field offsets and widths
package alu0_xbar_datapath_pkg;
   localparam int CFG_W       = 11;
   localparam int ALU_OP_LSB  = 0;
   localparam int OUT_SEL_BIT = 2;
   localparam int XBAR_LSB    = 3;
   localparam int XBAR_SEL_W  = 2;
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_XOR = 2'd3
   } alu_op_e;
endpackage

// File: rtl/alu0_xbar_datapath_xbar_sel.sv
// xbar_sel: N-input, 1-output word mux
//   i_data  N words in
//   i_sel   clog2(N)-bit select
//   o_data  selected word
module xbar_sel #(
   parameter int N = 4,
   parameter int W = 32
) (
   input  logic [N-1:0][W-1:0]     i_data,
   input  logic [$clog2(N)-1:0]    i_sel,
   output logic [W-1:0]            o_data
);
   assign o_data = i_data[i_sel];
endmodule

// File: rtl/alu0_xbar_datapath.sv
// alu0_xbar_datapath: 4x4 crossbar -> registered ALU -> 2x1 output mux, serial config
//   clk, reset (sync, active-low), config_en/config_in/config_out: 11-bit config chain
//   in0, in1, mem_in: data inputs; mem_op0, mem_op1: crossbar outputs 2/3; out0: PE output
module alu0_xbar_datapath
   import alu0_xbar_datapath_pkg::*;
#(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            config_en,
   input  logic            config_in,
   output logic            config_out,
   input  logic [size-1:0] in0,
   input  logic [size-1:0] in1,
   input  logic [size-1:0] mem_in,
   output logic [size-1:0] mem_op0,
   output logic [size-1:0] mem_op1,
   output logic [size-1:0] out0
);
   logic [CFG_W-1:0]      r_cfg;
   logic [size-1:0]       r_alu_q;
   logic [3:0][size-1:0]  w_xin;
   logic [3:0][size-1:0]  w_xout;
   logic [1:0][size-1:0]  w_oin;
   logic [size-1:0]       w_alu_d;
   alu_op_e               w_op;

   // i2 is the registered ALU result, so feedback routing never closes a loop
   assign w_xin = {mem_in, r_alu_q, in1, in0};

   for (genvar k = 0; k < 4; k++) begin : g_xbar
      xbar_sel #(.N(4), .W(size)) u_sel (
         .i_data (w_xin),
         .i_sel  (r_cfg[XBAR_LSB + XBAR_SEL_W*k +: XBAR_SEL_W]),
         .o_data (w_xout[k])
      );
   end

   assign w_op    = alu_op_e'(r_cfg[ALU_OP_LSB +: 2]);
   assign w_alu_d = (w_op == OP_ADD) ? w_xout[0] + w_xout[1] :
                    (w_op == OP_SUB) ? w_xout[0] - w_xout[1] :
                    (w_op == OP_MUL) ? w_xout[0] * w_xout[1] :
                                       w_xout[0] ^ w_xout[1];

   assign w_oin = {mem_in, r_alu_q};

   xbar_sel #(.N(2), .W(size)) u_out_sel (
      .i_data (w_oin),
      .i_sel  (r_cfg[OUT_SEL_BIT]),
      .o_data (out0)
   );

   assign mem_op0    = w_xout[2];
   assign mem_op1    = w_xout[3];
   assign config_out = r_cfg[CFG_W-1];

   // reset wins over shifting, discarding any partially loaded pattern
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cfg   <= '0;
         r_alu_q <= '0;
      end else begin
         if (config_en) r_cfg <= {r_cfg[CFG_W-2:0], config_in};
         r_alu_q <= w_alu_d;
      end
   end
endmodule

// File: tb/tb_alu0_xbar_datapath.sv
// tb_alu0_xbar_datapath: randomized and directed checks against a behavioural model
module tb_alu0_xbar_datapath;
   logic        clk = 0;
   logic        reset = 0;
   logic        config_en = 0;
   logic        config_in = 0;
   logic        config_out;
   logic [31:0] in0 = 0, in1 = 0, mem_in = 0;
   logic [31:0] mem_op0, mem_op1, out0;

   int n_checks = 0;
   int n_fail = 0;

   logic [10:0] m_cfg = 0;
   logic [31:0] m_alu = 0;

   alu0_xbar_datapath #(.size(32)) dut (
      .clk(clk), .reset(reset), .config_en(config_en), .config_in(config_in),
      .config_out(config_out), .in0(in0), .in1(in1), .mem_in(mem_in),
      .mem_op0(mem_op0), .mem_op1(mem_op1), .out0(out0)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] make_cfg(input logic [1:0] op, input logic osel,
      input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3);
      return {s3, s2, s1, s0, osel, op};
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] s);
      case (s)
         2'd0: return in0;
         2'd1: return in1;
         2'd2: return m_alu;
         default: return mem_in;
      endcase
   endfunction

   function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (op)
         2'd0: return a + b;
         2'd1: return a - b;
         2'd2: return p[31:0];
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [31:0] exp_out();
      return m_cfg[2] ? mem_in : m_alu;
   endfunction

   function automatic logic [31:0] exp_m0();
      return pick(m_cfg[8:7]);
   endfunction

   function automatic logic [31:0] exp_m1();
      return pick(m_cfg[10:9]);
   endfunction

   task automatic step();
      logic [31:0] nxt;
      nxt = alu_f(m_cfg[1:0], pick(m_cfg[4:3]), pick(m_cfg[6:5]));
      @(posedge clk);
      #1;
      if (!reset) begin
         m_cfg = '0;
         m_alu = '0;
      end else begin
         m_alu = nxt;
         if (config_en) m_cfg = {m_cfg[9:0], config_in};
      end
   endtask

   task automatic load_cfg(input logic [10:0] p);
      for (int i = 10; i >= 0; i--) begin
         config_en = 1;
         config_in = p[i];
         step();
      end
      config_en = 0;
      config_in = 0;
   endtask

   task automatic do_reset();
      reset = 0;
      step();
      reset = 1;
   endtask

   task automatic test_reset();
      in0 = 5; in1 = 0; mem_in = 0;
      reset = 0;
      step();
      n_checks++;
      if (out0 !== 32'd0) begin n_fail++; $display("FAIL reset_out0 got %h want 0", out0); end
      n_checks++;
      if (config_out !== 1'b0) begin n_fail++; $display("FAIL reset_cfgout got %b want 0", config_out); end
      reset = 1;
      step();
      n_checks++;
      if (out0 !== 32'd10) begin n_fail++; $display("FAIL reset_add got %h want 10", out0); end
      n_checks++;
      if (mem_op0 !== 32'd5 || mem_op1 !== 32'd5)
         begin n_fail++; $display("FAIL reset_memop got %h/%h want 5/5", mem_op0, mem_op1); end
   endtask

   task automatic test_sub_config();
      logic [10:0] p;
      p = make_cfg(2'd1, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0);
      do_reset();
      in0 = 3; in1 = 7;
      load_cfg(p);
      step();
      n_checks++;
      if (out0 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sub_out0 got %h want fffffffc", out0); end
      for (int i = 0; i < 11; i++) begin
         n_checks++;
         if (config_out !== p[10-i])
            begin n_fail++; $display("FAIL cfg_chain bit %0d got %b want %b", i, config_out, p[10-i]); end
         config_en = 1;
         config_in = 0;
         step();
      end
      config_en = 0;
   endtask

   task automatic test_accum();
      do_reset();
      in0 = 0; in1 = 0; mem_in = 0;
      load_cfg(make_cfg(2'd0, 1'b0, 2'd2, 2'd1, 2'd0, 2'd0));
      in1 = 1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out0 !== 32'(i)) begin n_fail++; $display("FAIL accum step %0d got %h want %h", i, out0, i); end
         step();
      end
   endtask

   task automatic test_mul_xor();
      load_cfg(make_cfg(2'd2, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0));
      in0 = 32'h10000; in1 = 32'h10000;
      step();
      n_checks++;
      if (out0 !== 32'd0) begin n_fail++; $display("FAIL mul_wrap got %h want 0", out0); end
      in0 = 32'd70000; in1 = 32'd3;
      step();
      n_checks++;
      if (out0 !== 32'd210000) begin n_fail++; $display("FAIL mul got %h want %h", out0, 32'd210000); end
      load_cfg(make_cfg(2'd3, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0));
      in0 = 32'hF0F0; in1 = 32'hFFFF;
      step();
      n_checks++;
      if (out0 !== 32'h0F0F) begin n_fail++; $display("FAIL xor got %h want 0f0f", out0); end
   endtask

   task automatic test_mem_routing();
      load_cfg(make_cfg(2'd0, 1'b1, 2'd0, 2'd1, 2'd3, 2'd1));
      mem_in = 32'hABCD; in1 = 9;
      #1;
      n_checks++;
      if (out0 !== 32'hABCD || mem_op0 !== 32'hABCD || mem_op1 !== 32'd9)
         begin n_fail++; $display("FAIL mem_route got %h/%h/%h want abcd/abcd/9", out0, mem_op0, mem_op1); end
      mem_in = 32'h1234;
      #1;
      n_checks++;
      if (out0 !== 32'h1234 || mem_op0 !== 32'h1234)
         begin n_fail++; $display("FAIL mem_comb got %h/%h want 1234/1234", out0, mem_op0); end
   endtask

   task automatic test_reset_mid_config();
      logic [10:0] p;
      p = make_cfg(2'd3, 1'b1, 2'd1, 2'd2, 2'd3, 2'd1);
      for (int i = 10; i > 4; i--) begin
         config_en = 1;
         config_in = p[i];
         step();
      end
      reset = 0;
      step();
      reset = 1;
      config_en = 0;
      in0 = 32'd11; in1 = 32'd22; mem_in = 32'd33;
      #1;
      n_checks++;
      if (config_out !== 1'b0 || out0 !== 32'd0 || mem_op0 !== 32'd11 || mem_op1 !== 32'd11)
         begin n_fail++; $display("FAIL mid_reset got %b/%h/%h/%h want 0/0/b/b", config_out, out0, mem_op0, mem_op1); end
      step();
      n_checks++;
      if (out0 !== 32'd22) begin n_fail++; $display("FAIL mid_reset_add got %h want 22", out0); end
      load_cfg(p);
      for (int i = 0; i < 100; i++) begin
         config_in = 1'($urandom);
         in0 = $urandom; in1 = $urandom; mem_in = $urandom;
         step();
         n_checks++;
         if (out0 !== exp_out() || mem_op0 !== exp_m0() || mem_op1 !== exp_m1() || config_out !== p[10])
            begin n_fail++; $display("FAIL hold cyc %0d got %h/%h/%h/%b want %h/%h/%h/%b", i,
               out0, mem_op0, mem_op1, config_out, exp_out(), exp_m0(), exp_m1(), p[10]); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) != 0);
         config_en = ($urandom_range(0, 3) == 0);
         config_in = 1'($urandom);
         in0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         in1 = $urandom;
         mem_in = $urandom;
         step();
         n_checks++;
         if (out0 !== exp_out() || mem_op0 !== exp_m0() || mem_op1 !== exp_m1() || config_out !== m_cfg[10])
            begin n_fail++; $display("FAIL random cyc %0d got %h/%h/%h/%b want %h/%h/%h/%b", i,
               out0, mem_op0, mem_op1, config_out, exp_out(), exp_m0(), exp_m1(), m_cfg[10]); end
      end
      reset = 1;
      config_en = 0;
   endtask

   initial begin
      test_reset();
      test_sub_config();
      test_accum();
      test_mul_xor();
      test_mem_routing();
      test_reset_mid_config();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
